// File: rtl/modn_down_ctr.sv
// Programmable mod-N down counter with reload register, one-shot and
// periodic modes, abort, and a terminal-count pulse.
module modn_down_ctr #(
  parameter int unsigned N     = 10,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             start,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             cnt_zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RLD_RESET = WIDTH'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             cnt_zero_nxt;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] rld_nxt;
  logic [WIDTH-1:0] start_val;

  // State, count, pulse and reload registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out      <= '0;
      cnt_zero <= 1'b0;
      rld      <= RLD_RESET;
    end else begin
      state    <= state_nxt;
      out      <= out_nxt;
      cnt_zero <= cnt_zero_nxt;
      rld      <= rld_nxt;
    end
  end

  // Next-state, next-count and reload update; a same-cycle load feeds the start/reload value.
  always_comb begin
    state_nxt    = state;
    out_nxt      = out;
    cnt_zero_nxt = 1'b0;
    rld_nxt      = load ? load_val : rld;
    start_val    = load ? load_val : rld;

    unique case (state)
      IDLE, DONE: begin
        // abort outranks start even when nothing is running
        if (start && !abort) begin
          out_nxt   = start_val;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (enb) begin
          if (out != '0) begin
            out_nxt = out - WIDTH'(1);
          end else begin
            cnt_zero_nxt = 1'b1;
            if (auto_reload) begin
              out_nxt = start_val;
            end else begin
              state_nxt = DONE;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags are pure decodes of the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_modn_down_ctr.sv
// Directed self-checking bench for modn_down_ctr (N=10, WIDTH=8).
module tb_modn_down_ctr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       auto_reload = 1'b0;
  logic [7:0] out;
  logic       cnt_zero;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  modn_down_ctr #(.N(10), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enb(enb), .start(start), .abort(abort),
    .load(load), .load_val(load_val), .auto_reload(auto_reload),
    .out(out), .cnt_zero(cnt_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({out, cnt_zero, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: out=%0d z=%b busy=%b done=%b, want 0 0 0 0", out, cnt_zero, busy, done);
    end
    // enb outside RUN has no effect
    enb = 1'b1;
    step();
    step();
    n_checks++;
    if ({out, cnt_zero, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_enb: out=%0d z=%b busy=%b done=%b, want 0 0 0 0", out, cnt_zero, busy, done);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] exp_out;
    logic       exp_z;
    int         pulses;
    auto_reload = 1'b1;
    enb = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({out, cnt_zero, busy} !== {8'd9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL periodic_start: out=%0d z=%b busy=%b, want 9 0 1", out, cnt_zero, busy);
    end
    exp_out = 8'd9;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      if (exp_out == 8'd0) begin
        exp_out = 8'd9;
        exp_z = 1'b1;
      end else begin
        exp_out = exp_out - 8'd1;
        exp_z = 1'b0;
      end
      step();
      if (cnt_zero) pulses++;
      n_checks++;
      if ({out, cnt_zero, busy, done} !== {exp_out, exp_z, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL periodic_k%0d: out=%0d z=%b busy=%b done=%b, want %0d %b 1 0",
                 k, out, cnt_zero, busy, done, exp_out, exp_z);
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL periodic_pulses: got %0d, want 2", pulses);
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_out [5] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic       exp_z   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_d   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    abort = 1'b1;
    step();
    abort = 1'b0;
    load = 1'b1;
    load_val = 8'd3;
    step();
    load = 1'b0;
    auto_reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({out, busy} !== {8'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL oneshot_start: out=%0d busy=%b, want 3 1", out, busy);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if ({out, cnt_zero, busy, done} !== {exp_out[k], exp_z[k], ~exp_d[k], exp_d[k]}) begin
        n_fail++;
        $display("FAIL oneshot_k%0d: out=%0d z=%b busy=%b done=%b, want %0d %b %b %b",
                 k, out, cnt_zero, busy, done, exp_out[k], exp_z[k], ~exp_d[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_enb_gating();
    logic       en_seq  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] exp_out [6] = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0};
    logic       exp_z   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         enabled;
    start = 1'b1;
    step();
    start = 1'b0;
    enabled = 0;
    for (int k = 0; k < 6; k++) begin
      enb = en_seq[k];
      if (en_seq[k]) enabled++;
      step();
      n_checks++;
      if ({out, cnt_zero} !== {exp_out[k], exp_z[k]}) begin
        n_fail++;
        $display("FAIL gating_k%0d: out=%0d z=%b, want %0d %b", k, out, cnt_zero, exp_out[k], exp_z[k]);
      end
    end
    enb = 1'b1;
    n_checks++;
    if ({enabled, done} !== {32'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL gating_total: enabled=%0d done=%b, want 4 1", enabled, done);
    end
  endtask

  task automatic test_abort();
    load = 1'b1;
    load_val = 8'd9;
    step();
    load = 1'b0;
    auto_reload = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    n_checks++;
    if (out !== 8'd5) begin
      n_fail++;
      $display("FAIL abort_pre: out=%0d, want 5", out);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({out, cnt_zero, busy, done} !== {8'd5, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_idle: out=%0d z=%b busy=%b done=%b, want 5 0 0 0", out, cnt_zero, busy, done);
    end
    repeat (3) step();
    n_checks++;
    if ({out, cnt_zero, busy} !== {8'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_hold: out=%0d z=%b busy=%b, want 5 0 0", out, cnt_zero, busy);
    end
    start = 1'b1;
    step();
    n_checks++;
    if ({out, busy} !== {8'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_restart: out=%0d busy=%b, want 9 1", out, busy);
    end
    // start held while running is ignored
    step();
    step();
    start = 1'b0;
    n_checks++;
    if ({out, busy} !== {8'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL start_in_run: out=%0d busy=%b, want 7 1", out, busy);
    end
  endtask

  task automatic test_zero_reload();
    abort = 1'b1;
    step();
    abort = 1'b0;
    load = 1'b1;
    load_val = 8'd0;
    start = 1'b1;
    auto_reload = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({out, cnt_zero, busy} !== {8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_start: out=%0d z=%b busy=%b, want 0 0 1", out, cnt_zero, busy);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if ({out, cnt_zero, busy} !== {8'd0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL zero_periodic_k%0d: out=%0d z=%b busy=%b, want 0 1 1", k, out, cnt_zero, busy);
      end
    end
    enb = 1'b0;
    step();
    n_checks++;
    if ({cnt_zero, busy} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_disabled: z=%b busy=%b, want 0 1", cnt_zero, busy);
    end
    enb = 1'b1;
    auto_reload = 1'b0;
    step();
    n_checks++;
    if ({out, cnt_zero, busy, done} !== {8'd0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_oneshot: out=%0d z=%b busy=%b done=%b, want 0 1 0 1", out, cnt_zero, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1;
    load_val = 8'd7;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    repeat (3) step();
    n_checks++;
    if (out !== 8'd4) begin
      n_fail++;
      $display("FAIL rst_mid_pre: out=%0d, want 4", out);
    end
    // reset beats a simultaneous start and load
    rst = 1'b1;
    start = 1'b1;
    load = 1'b1;
    load_val = 8'd2;
    step();
    rst = 1'b0;
    start = 1'b0;
    load = 1'b0;
    n_checks++;
    if ({out, cnt_zero, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid: out=%0d z=%b busy=%b done=%b, want 0 0 0 0", out, cnt_zero, busy, done);
    end
    step();
    n_checks++;
    if ({out, cnt_zero, busy} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_after: out=%0d z=%b busy=%b, want 0 0 0", out, cnt_zero, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({out, busy} !== {8'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_rld: out=%0d busy=%b, want 9 1", out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_enb_gating();
    test_abort();
    test_zero_reload();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
